// File: rtl/microc_pkg.sv
// Shared definitions for the microc control unit: opcode encodings,
// ALU operation codes, FSM states and the datapath control word.
package microc_pkg;

  // Opcode encodings (6-bit)
  localparam logic [5:0] OP_NOP    = 6'b000000;
  localparam logic [5:0] OP_J      = 6'b000001;
  localparam logic [5:0] OP_JZ     = 6'b000010;
  localparam logic [5:0] OP_JNZ    = 6'b000011;
  localparam logic [5:0] OP_HALT   = 6'b001111;
  // Load-immediate occupies 0001xx
  localparam logic [3:0] OP_LI_PFX = 4'b0001;
  // Opcode[5]=1 marks an ALU instruction; Opcode[4:2] carry the ALU op
  localparam int         OP_ALU_BIT = 5;

  // ALU operation encodings (the datapath interprets Opcode[4:2] directly)
  localparam logic [2:0] ALU_OP_0 = 3'b000;
  localparam logic [2:0] ALU_OP_1 = 3'b001;
  localparam logic [2:0] ALU_OP_2 = 3'b010;
  localparam logic [2:0] ALU_OP_3 = 3'b011;
  localparam logic [2:0] ALU_OP_4 = 3'b100;
  localparam logic [2:0] ALU_OP_5 = 3'b101;
  localparam logic [2:0] ALU_OP_6 = 3'b110;
  localparam logic [2:0] ALU_OP_7 = 3'b111;

  // Execution-enable FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } uc_state_e;

  // Datapath control word
  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] alu_op;
    logic       pc_we;
  } ctrl_word_t;

  // Word driven whenever no instruction executes: PC holds, nothing written
  localparam ctrl_word_t CTRL_IDLE = '{
    s_inc:  1'b1,
    s_inm:  1'b0,
    we:     1'b0,
    wez:    1'b0,
    alu_op: ALU_OP_0,
    pc_we:  1'b0
  };

endpackage

// File: rtl/uc_decode.sv
// Purely combinational instruction decoder: Opcode/zero -> control word,
// plus flags for undefined opcodes and the HALT instruction.
module uc_decode
  import microc_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic        zero,
  output ctrl_word_t  ctrl,
  output logic        is_illegal,
  output logic        is_halt
);

  // Decode the opcode; undefined encodings behave as NOP and raise is_illegal
  always_comb begin
    ctrl       = CTRL_IDLE;
    ctrl.pc_we = 1'b1;
    is_illegal = 1'b0;
    is_halt    = 1'b0;
    if (opcode[OP_ALU_BIT]) begin
      ctrl.alu_op = opcode[4:2];
      ctrl.we     = 1'b1;
      ctrl.wez    = 1'b1;
    end else if (opcode[5:2] == OP_LI_PFX) begin
      ctrl.s_inm = 1'b1;
      ctrl.we    = 1'b1;
    end else begin
      case (opcode)
        OP_NOP:  ctrl.s_inc = 1'b1;
        OP_J:    ctrl.s_inc = 1'b0;
        OP_JZ:   ctrl.s_inc = ~zero;
        OP_JNZ:  ctrl.s_inc = zero;
        OP_HALT: begin
          ctrl.pc_we = 1'b0;
          is_halt    = 1'b1;
        end
        default: is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/microc_uc.sv
// microc control unit: wraps uc_decode with an IDLE/RUN/HALT execution FSM,
// debug single-step gating, a sticky illegal-opcode flag and, when the macro
// MICROC_UC_PERF_CNT_EN is defined, instruction / taken-branch counters.
module microc_uc
  import microc_pkg::*;
`ifdef MICROC_UC_PERF_CNT_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic             wez,
  output logic [2:0]       ALUOp,
  output logic             pc_we,
  output logic             halted,
  output logic             illegal
`ifdef MICROC_UC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  uc_state_e  state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       exe_s;
  ctrl_word_t dec_ctrl_s;
  ctrl_word_t ctrl_s;
  logic       dec_illegal_s;
  logic       dec_halt_s;

  uc_decode u_decode (
    .opcode     (Opcode),
    .zero       (zero),
    .ctrl       (dec_ctrl_s),
    .is_illegal (dec_illegal_s),
    .is_halt    (dec_halt_s)
  );

  // FSM state and sticky illegal flag, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic and execute qualifier (step is sampled every cycle)
  always_comb begin
    state_d = state_q;
    exe_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        exe_s = !step_mode || step;
        if (exe_s && dec_halt_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Gate the decoded word with exe and update the sticky illegal flag
  always_comb begin
    ctrl_s    = CTRL_IDLE;
    illegal_d = illegal_q;
    if (exe_s) begin
      ctrl_s    = dec_ctrl_s;
      illegal_d = illegal_q | dec_illegal_s;
    end else begin
      ctrl_s    = CTRL_IDLE;
      illegal_d = illegal_q;
    end
  end

  assign s_inc   = ctrl_s.s_inc;
  assign s_inm   = ctrl_s.s_inm;
  assign we      = ctrl_s.we;
  assign wez     = ctrl_s.wez;
  assign ALUOp   = ctrl_s.alu_op;
  assign pc_we   = ctrl_s.pc_we;
  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;

`ifdef MICROC_UC_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  // Counter increments: executed non-HALT instructions and taken jumps
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (exe_s && !dec_halt_s) begin
      instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instr_cnt_d = instr_cnt_q;
    end
    if (exe_s && !ctrl_s.s_inc) begin
      taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      taken_cnt_d = taken_cnt_q;
    end
  end

  // Performance counter registers, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_cnt_q <= {CNT_W{1'b0}};
      taken_cnt_q <= {CNT_W{1'b0}};
    end else begin
      instr_cnt_q <= instr_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_microc_uc.sv
// Directed self-checking bench for microc_uc. Control word is compared as
// {s_inc, s_inm, we, wez, ALUOp[2:0], pc_we}.
module tb_microc_uc;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic       zero;
  logic       start;
  logic       step_mode;
  logic       step;
  logic       s_inc;
  logic       s_inm;
  logic       we;
  logic       wez;
  logic [2:0] ALUOp;
  logic       pc_we;
  logic       halted;
  logic       illegal;
`ifdef MICROC_UC_PERF_CNT_EN
  logic [15:0] instr_cnt;
  logic [15:0] taken_cnt;
`endif

  int total;
  int bad;

  logic [7:0] word;
  assign word = {s_inc, s_inm, we, wez, ALUOp, pc_we};

  localparam logic [7:0] W_IDLE   = 8'b1000_0000;
  localparam logic [7:0] W_NOP    = 8'b1000_0001;
  localparam logic [7:0] W_TAKEN  = 8'b0000_0001;
  localparam logic [7:0] W_LI     = 8'b1110_0001;
  localparam logic [7:0] W_ALU0   = 8'b1011_0001;
  localparam logic [7:0] W_ALU1   = 8'b1011_0011;
  localparam logic [7:0] W_ALU7   = 8'b1011_1111;

  microc_uc dut (
    .clk       (clk),
    .reset     (reset),
    .Opcode    (Opcode),
    .zero      (zero),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .s_inc     (s_inc),
    .s_inm     (s_inm),
    .we        (we),
    .wez       (wez),
    .ALUOp     (ALUOp),
    .pc_we     (pc_we),
    .halted    (halted),
    .illegal   (illegal)
`ifdef MICROC_UC_PERF_CNT_EN
    ,
    .instr_cnt (instr_cnt),
    .taken_cnt (taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge to enter RUN
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; Opcode = 6'b100100; zero = 1'b0; start = 1'b0;
    step_mode = 1'b0; step = 1'b0;
    tick(); #1;
    total++;
    if (word !== W_IDLE) begin
      bad++; $display("FAIL reset_word: got %b exp %b", word, W_IDLE);
    end
    total++;
    if ({halted, illegal} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: got %b exp 00", {halted, illegal});
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (word !== W_IDLE || halted !== 1'b0) begin
      bad++; $display("FAIL idle_nostart: got %b/%b exp %b/0", word, halted, W_IDLE);
    end
  endtask

  task automatic test_alu();
    do_start();
    Opcode = 6'b100100; #1;
    total++;
    if (word !== W_ALU1) begin
      bad++; $display("FAIL alu_001: got %b exp %b", word, W_ALU1);
    end
    Opcode = 6'b111110; #1;
    total++;
    if (word !== W_ALU7) begin
      bad++; $display("FAIL alu_111: got %b exp %b", word, W_ALU7);
    end
    tick();
  endtask

  task automatic test_branch();
    Opcode = 6'b000010; zero = 1'b1; #1;
    total++;
    if (word !== W_TAKEN) begin
      bad++; $display("FAIL jz_taken: got %b exp %b", word, W_TAKEN);
    end
    zero = 1'b0; #1;
    total++;
    if (word !== W_NOP) begin
      bad++; $display("FAIL jz_not_taken: got %b exp %b", word, W_NOP);
    end
    Opcode = 6'b000011; zero = 1'b1; #1;
    total++;
    if (word !== W_NOP) begin
      bad++; $display("FAIL jnz_not_taken: got %b exp %b", word, W_NOP);
    end
    zero = 1'b0; #1;
    total++;
    if (word !== W_TAKEN) begin
      bad++; $display("FAIL jnz_taken: got %b exp %b", word, W_TAKEN);
    end
    Opcode = 6'b000001; #1;
    total++;
    if (word !== W_TAKEN) begin
      bad++; $display("FAIL j: got %b exp %b", word, W_TAKEN);
    end
    tick();
  endtask

  task automatic test_li();
    Opcode = 6'b000101; #1;
    total++;
    if (word !== W_LI) begin
      bad++; $display("FAIL li: got %b exp %b", word, W_LI);
    end
    Opcode = 6'b000000; #1;
    total++;
    if (word !== W_NOP) begin
      bad++; $display("FAIL nop: got %b exp %b", word, W_NOP);
    end
    tick();
  endtask

  task automatic test_illegal();
    Opcode = 6'b010000; #1;
    total++;
    if (word !== W_NOP || illegal !== 1'b0) begin
      bad++; $display("FAIL illegal_exec: got %b/%b exp %b/0", word, illegal, W_NOP);
    end
    tick();
    total++;
    if (illegal !== 1'b1) begin
      bad++; $display("FAIL illegal_set: got %b exp 1", illegal);
    end
    Opcode = 6'b100000;
    tick(); tick();
    total++;
    if (illegal !== 1'b1 || word !== W_ALU0) begin
      bad++; $display("FAIL illegal_sticky: got %b/%b exp 1/%b", illegal, word, W_ALU0);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (illegal !== 1'b0 || word !== W_IDLE || halted !== 1'b0) begin
      bad++; $display("FAIL midcycle_reset: got %b/%b/%b exp 0/%b/0", illegal, word, halted, W_IDLE);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_halt();
    do_start();
    Opcode = 6'b001111; #1;
    total++;
    if (word !== W_IDLE || halted !== 1'b0) begin
      bad++; $display("FAIL halt_exec: got %b/%b exp %b/0", word, halted, W_IDLE);
    end
    tick();
    total++;
    if (halted !== 1'b1) begin
      bad++; $display("FAIL halted_set: got %b exp 1", halted);
    end
    Opcode = 6'b100100; start = 1'b1;
    tick(); tick();
    total++;
    if (word !== W_IDLE || halted !== 1'b1) begin
      bad++; $display("FAIL halt_hold: got %b/%b exp %b/1", word, halted, W_IDLE);
    end
    start = 1'b0;
    reset = 1'b0; #1;
    total++;
    if (halted !== 1'b0 || word !== W_IDLE) begin
      bad++; $display("FAIL halt_reset: got %b/%b exp 0/%b", halted, word, W_IDLE);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_step();
    logic [5:0] pattern;
    int nexec;
    pattern = 6'b001001;
    nexec = 0;
    step_mode = 1'b1; step = 1'b0;
    Opcode = 6'b100000;
    do_start();
    for (int i = 0; i < 6; i++) begin
      step = pattern[i]; #1;
      total++;
      if (word !== (pattern[i] ? W_ALU0 : W_IDLE)) begin
        bad++; $display("FAIL step_cycle%0d: got %b exp %b", i, word,
                        (pattern[i] ? W_ALU0 : W_IDLE));
      end
      if (we && pc_we) nexec++;
      tick();
    end
    step = 1'b0;
    total++;
    if (nexec !== 2) begin
      bad++; $display("FAIL step_count: got %0d exp 2", nexec);
    end
`ifdef MICROC_UC_PERF_CNT_EN
    total++;
    if (instr_cnt !== 16'd2 || taken_cnt !== 16'd0) begin
      bad++; $display("FAIL perf_step: got %0d/%0d exp 2/0", instr_cnt, taken_cnt);
    end
    step_mode = 1'b0; Opcode = 6'b000001;
    tick();
    Opcode = 6'b001111;
    tick();
    total++;
    if (instr_cnt !== 16'd3 || taken_cnt !== 16'd1) begin
      bad++; $display("FAIL perf_jump_halt: got %0d/%0d exp 3/1", instr_cnt, taken_cnt);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_alu();
    test_branch();
    test_li();
    test_illegal();
    test_halt();
    test_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microc_uc.md
Name: microc_uc

Overview:
- Control unit that drives the microc datapath.
- Consumes the datapath's Opcode and zero flag.
- Generates the datapath control word: s_inc, s_inm, we, wez, ALUOp, plus a new pc_we gate.
- Single-cycle decode within an execution-enable FSM (IDLE/RUN/HALT) that adds start, halt and debug single-step.

Parameters:
- CNT_W, 16, width of performance counters (used only with MICROC_UC_PERF_CNT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Opcode  input  6  current instruction opcode from datapath.
- zero  input  1  registered zero flag from datapath.
- start  input  1  leave IDLE and begin execution.
- step_mode  input  1  1 = single-step debug mode.
- step  input  1  one-cycle pulse; executes one instruction when step_mode=1.
- s_inc  output  1  PC mux select: 1 = PC+1, 0 = jump target.
- s_inm  output  1  register-file write mux: 1 = immediate, 0 = ALU result.
- we  output  1  register-file write enable.
- wez  output  1  zero-flag write enable.
- ALUOp  output  3  ALU operation.
- pc_we  output  1  PC load enable (datapath gates its PC register with it).
- halted  output  1  1 while in HALT.
- illegal  output  1  sticky: an undefined opcode was executed.

Behaviour:
- States: IDLE (reset state), RUN, HALT. State register is cleared asynchronously when reset=0.
- IDLE -> RUN on a clk edge with start=1. The first instruction executes in the following cycle. start is ignored in RUN and HALT.
- exe = (state==RUN) && (!step_mode || step). exe is combinational; step is sampled per cycle, so a 3-cycle-high step executes 3 instructions.
- exe=0 idle word: s_inc=1, s_inm=0, we=0, wez=0, ALUOp=000, pc_we=0. These are also the reset values of all control outputs.
- Decode, combinational on Opcode/zero, valid only when exe=1:
  - Opcode[5]=1 ALU: ALUOp=Opcode[4:2], we=1, wez=1, s_inm=0, s_inc=1, pc_we=1. Opcode[1:0] are don't-care.
  - 000000 NOP: pc_we=1, s_inc=1, no writes.
  - 000001 J: s_inc=0, pc_we=1.
  - 000010 JZ: s_inc=~zero, pc_we=1.
  - 000011 JNZ: s_inc=zero, pc_we=1.
  - 0001xx LI: s_inm=1, we=1, wez=0, s_inc=1, pc_we=1.
  - 001111 HALT: pc_we=0, no writes. Next state is HALT.
  - Any other opcode: illegal. Executes as NOP, and illegal is set on the clk edge.
- Outputs are combinational in state/Opcode/zero; decode latency is 0 cycles. Register writes, the zero flag and the PC all update on the same edge.
- halted=1 from the edge following the HALT instruction. HALT is left only via reset; in HALT the idle word is forced.
- illegal is cleared only by reset.
- Reset asserted mid-RUN: immediately state=IDLE, idle word on outputs, halted=0, illegal=0, counters=0.
- JZ/JNZ use zero as presented by the datapath. A JZ immediately after an ALU op sees the flag written on the previous edge; no forwarding is done here.

Optional Feature:
- Macro: MICROC_UC_PERF_CNT_EN.
- When defined, adds two outputs:
  - instr_cnt [CNT_W-1:0]: increments on each edge with exe=1 and a non-HALT opcode.
  - taken_cnt [CNT_W-1:0]: increments on each edge where exe=1 and s_inc=0.
- Both counters wrap modulo 2^CNT_W and are cleared by reset.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package microc_pkg holds:
  - opcode constants: OP_NOP, OP_J, OP_JZ, OP_JNZ, OP_LI prefix, OP_HALT, ALU prefix bit;
  - ALUOp encodings;
  - FSM state enum (IDLE/RUN/HALT).
- Sub-module uc_decode: purely combinational Opcode/zero -> control word plus an is_illegal and is_halt flag.
- microc_uc wraps uc_decode with the FSM, exe gating, sticky flag and counters.

Test Plan:
- Reset 0->1, start=0 for 3 cycles -> pc_we=0, we=0, halted=0. Pulse start, then Opcode=100100 -> ALUOp=001, we=1, wez=1, s_inc=1, pc_we=1.
- RUN, Opcode=000010: zero=1 -> s_inc=0, pc_we=1, we=0; zero=0 -> s_inc=1. Opcode=000011 with zero=1 -> s_inc=1.
- Opcode=000101 -> s_inm=1, we=1, wez=0, s_inc=1. Opcode=000001 -> s_inc=0, we=0.
- Opcode=001111 -> pc_we=0 that cycle; halted=1 next edge. Then ALU opcodes plus start pulses -> we=0, pc_we=0. Reset -> IDLE, halted=0.
- step_mode=1, step pulsed on 2 of 6 cycles with Opcode=100000 -> exactly 2 cycles with we=1/pc_we=1. With MICROC_UC_PERF_CNT_EN: instr_cnt=2, taken_cnt=0.
- Opcode=010000 -> pc_we=1, we=0, illegal=1 after edge and held through later legal opcodes. Reset asserted mid-cycle -> illegal=0 and idle word before the next clk edge.
